parameterized_skid_register: RTL and testbench
==============================================

Name: parameterized_skid_register

Overview:
- Elastic pipeline register: a WIDTH-bit data register with a valid/ready handshake on both sides.
- Adds a one-entry skid buffer so in_ready depends only on internal state, never combinationally on out_ready.
- Adds a synchronous flush for pipeline squash and an occupancy output.
- Used between CPU pipeline stages in place of plain enable-registers. Sustains one beat per cycle with 1-cycle latency.

Parameters:
- WIDTH, 32, data bits per beat.
- RESET_VALUE, 0 (WIDTH bits), value loaded into both data registers on reset and on flush.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous squash of all held beats.
- in_data  input  WIDTH  upstream beat.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  block can accept a beat this cycle.
- out_data  output  WIDTH  downstream beat (main register).
- out_valid  output  1  out_data holds a beat.
- out_ready  input  1  downstream accepts out_data this cycle.
- count  output  2  beats held: 0, 1 or 2.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
  - Port reset low immediately forces the reset state, independent of clk.
  - Release is sampled on the next rising clk.
- Storage: main register (drives out_data) and skid register. All state updates occur on rising clk.
- Reset state: state=EMPTY; main=skid=RESET_VALUE; out_valid=0; in_ready=1; count=0; out_data=RESET_VALUE.
- Transfer definitions:
  - accept = in_valid & in_ready.
  - drain = out_valid & out_ready.
- Decoded outputs: in_ready = (state!=FULL); out_valid = (state!=EMPTY). Both are decoded from state only, with no combinational path from out_ready or in_valid.
- State EMPTY (count=0):
  - accept -> BUSY; main<=in_data.
  - Otherwise hold.
- State BUSY (count=1):
  - accept & drain -> BUSY; main<=in_data.
  - accept & !drain -> FULL; skid<=in_data; main unchanged.
  - !accept & drain -> EMPTY; main unchanged.
  - Neither -> hold.
- State FULL (count=2):
  - in_ready=0, so in_valid is ignored.
  - drain -> BUSY; main<=skid.
  - Otherwise hold.
- Ordering: beats leave in arrival order; no beat is duplicated or dropped except by flush.
- Stability: while out_valid=1 & out_ready=0, out_data and out_valid do not change.
- Flush (synchronous): has priority over every transition in the same cycle.
  - Next state=EMPTY; main=skid=RESET_VALUE; count=0.
  - A beat offered with in_valid in the flush cycle is discarded.
  - A drain in the flush cycle still completes downstream, because the consumer already sampled it.
- Reset mid-operation: all held beats are lost; outputs match the reset state within the same cycle reset falls.
- Data-register updates: occur only on the transitions listed above. No X propagation into main or skid when in_valid=0.
- Illegal state encoding: recovers to EMPTY on the next clk.
- Throughput: 1 beat/cycle when out_ready is held high. Latency from accept to out_valid is 1 cycle.

Test Plan (WIDTH=8, RESET_VALUE=8'h00):
- Reset: drive reset=0 mid-cycle with a beat held -> out_valid=0, in_ready=1, count=0, out_data=8'h00 before the next clk edge.
- Streaming: out_ready=1; send 8'h11, 8'h22, 8'h33 on consecutive cycles -> out_data shows 8'h11, 8'h22, 8'h33 on consecutive cycles, 1-cycle latency; count stays 1; in_ready stays 1.
- Backpressure: out_ready=0; send 8'hA1, 8'hA2 -> count=2, in_ready=0; 8'hA3 held on in_data is not accepted. Raise out_ready -> output order 8'hA1, 8'hA2, then 8'hA3 after it is accepted; no loss or duplication.
- Flush: FULL with 8'hB1/8'hB2; assert flush with in_valid=1 carrying 8'hB3 -> next cycle count=0, out_valid=0, out_data=8'h00; 8'hB3 never appears at the output.
- Random stress: 1000 cycles of random in_valid, out_ready and flush with a scoreboard:
  - The output sequence equals the accepted-beat sequence, minus beats squashed by flush.
  - in_ready never depends on same-cycle out_ready.
  - out_data stays stable while stalled.

Source files
------------

// File: rtl/parameterized_skid_register.sv
// parameterized_skid_register: elastic valid/ready pipeline register with a one-entry skid buffer, flush and occupancy
module parameterized_skid_register #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       count
);
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;
  logic [1:0] state, state_nxt;
  logic [WIDTH-1:0] main, skid;
  logic accept, drain, main_ld, skid_ld, main_from_skid;
  assign accept = in_valid & in_ready;
  assign drain = out_valid & out_ready;
  assign main_ld = accept & ((state == EMPTY) | ((state == BUSY) & drain));
  assign skid_ld = accept & (state == BUSY) & ~drain;
  assign main_from_skid = (state == FULL) & drain;
  assign out_data = main;
  // State register; the encoding 2'd3 falls into the default branch below and returns to EMPTY
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= EMPTY;
    else state <= state_nxt;
  // Next state; flush overrides every handshake transition
  always_comb begin
    state_nxt = EMPTY;
    if (!flush)
      case (state)
        EMPTY:   state_nxt = accept ? BUSY : EMPTY;
        BUSY:    state_nxt = (accept & ~drain) ? FULL : (~accept & drain) ? EMPTY : BUSY;
        FULL:    state_nxt = drain ? BUSY : FULL;
        default: state_nxt = EMPTY;
      endcase
  end
  // Outputs decoded from state alone so in_ready never sees out_ready combinationally
  always_comb begin
    in_ready = state != FULL;
    out_valid = state != EMPTY;
    count = (state == BUSY) ? 2'd1 : (state == FULL) ? 2'd2 : 2'd0;
  end
  // Data registers move only on the listed transitions; the skid feeds main when the full pipe drains
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      main <= RESET_VALUE;
      skid <= RESET_VALUE;
    end else if (flush) begin
      main <= RESET_VALUE;
      skid <= RESET_VALUE;
    end else begin
      if (main_from_skid) main <= skid;
      else if (main_ld) main <= in_data;
      if (skid_ld) skid <= in_data;
    end
endmodule

// File: tb/tb_parameterized_skid_register.sv
// tb_parameterized_skid_register: scoreboard bench with a queue model of held beats
module tb_parameterized_skid_register;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [7:0] out_data;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [1:0] count;
  logic [7:0] q[$];
  int checks = 0;
  int errors = 0;
  logic pv = 1'b0;
  logic pr = 1'b0;
  logic pf = 1'b0;
  logic [7:0] pd = 8'h00;

  parameterized_skid_register #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; the model queue takes a beat when it has room and no flush squashes it
  task automatic cyc(input logic v, input logic [7:0] d, input logic r, input logic f);
    @(negedge clk);
    #1;
    in_valid = v;
    in_data = d;
    out_ready = r;
    flush = f;
    if (v && q.size() < 2 && !f) q.push_back(d);
  endtask

  // Monitor: state checks at the falling edge, then drain/flush bookkeeping once inputs are settled
  always @(negedge clk) begin
    if (!reset) pv = 1'b0;
    else begin
      chk("count", {6'b0, count}, 8'(q.size()));
      chk("in_ready", {7'b0, in_ready}, {7'b0, q.size() < 2});
      chk("out_valid", {7'b0, out_valid}, {7'b0, q.size() > 0});
      if (pv && !pr && !pf) chk("stall_data", out_data, pd);
      #2;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("drain_unexpected", 8'h01, 8'h00);
        else chk("out_data", out_data, q.pop_front());
      end
      if (flush) q.delete();
      pv = out_valid;
      pr = out_ready;
      pf = flush;
      pd = out_data;
    end
  end

  initial begin
    #2;
    chk("rst_out_valid", {7'b0, out_valid}, 8'h00);
    chk("rst_in_ready", {7'b0, in_ready}, 8'h01);
    chk("rst_count", {6'b0, count}, 8'h00);
    chk("rst_out_data", out_data, 8'h00);
    @(negedge clk);
    #1;
    reset = 1'b1;
    cyc(1, 8'h11, 1, 0);
    cyc(1, 8'h22, 1, 0);
    cyc(1, 8'h33, 1, 0);
    cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 1, 0);
    cyc(1, 8'hA1, 0, 0);
    cyc(1, 8'hA2, 0, 0);
    cyc(1, 8'hA3, 0, 0);
    cyc(1, 8'hA3, 1, 0);
    cyc(1, 8'hA3, 1, 0);
    cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 1, 0);
    cyc(1, 8'hB1, 0, 0);
    cyc(1, 8'hB2, 0, 0);
    cyc(1, 8'hB3, 0, 1);
    cyc(0, 8'h00, 1, 0);
    #1;
    chk("flush_out_data", out_data, 8'h00);
    chk("flush_count", {6'b0, count}, 8'h00);
    cyc(0, 8'h00, 1, 0);
    cyc(1, 8'hC1, 0, 0);
    cyc(0, 8'h00, 0, 0);
    #6;
    reset = 1'b0;
    #1;
    chk("arst_out_valid", {7'b0, out_valid}, 8'h00);
    chk("arst_in_ready", {7'b0, in_ready}, 8'h01);
    chk("arst_count", {6'b0, count}, 8'h00);
    chk("arst_out_data", out_data, 8'h00);
    q.delete();
    @(negedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 1000; i++)
      cyc(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0, ($urandom % 32) == 0);
    for (int i = 0; i < 4; i++) cyc(0, 8'h00, 1, 0);
    @(negedge clk);
    #3;
    chk("final_empty", 8'(q.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
